// File: rtl/vram_access_arbiter_pkg.sv
// Shared VDP definitions: VRAM geometry and the return-pipeline source tags.
package vram_access_arbiter_pkg;

  localparam int VRAM_AW = 14;

  typedef enum logic [1:0] {
    TAG_NONE   = 2'd0,
    TAG_CPU_RD = 2'd1,
    TAG_CPU_WR = 2'd2,
    TAG_REN    = 2'd3
  } tag_e;

  function automatic tag_e grant_tag(input logic cpu_gnt, input logic cpu_we,
                                     input logic ren_gnt);
    if (cpu_gnt)      return cpu_we ? TAG_CPU_WR : TAG_CPU_RD;
    else if (ren_gnt) return TAG_REN;
    else              return TAG_NONE;
  endfunction

endpackage

// File: rtl/vram_arb_retpipe.sv
// Return pipeline: tags each issued access, captures VRAM read data one cycle after
// issue and produces the cpu_ack / ren_valid pulses two cycles after the grant.
module vram_arb_retpipe
  import vram_access_arbiter_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [1:0]    i_tag,
  input  logic [DW-1:0] i_mem_rdat,
  output logic          o_cpu_ack,
  output logic [DW-1:0] o_cpu_rdat,
  output logic          o_ren_valid,
  output logic [DW-1:0] o_ren_rdat
);

  tag_e          r_tag_p0;
  tag_e          r_tag_p1;
  logic [DW-1:0] r_cpu_rdat;
  logic [DW-1:0] r_ren_rdat;

  // p0: access sits on the VRAM port; p1: its read data has been captured
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tag_p0   <= TAG_NONE;
      r_tag_p1   <= TAG_NONE;
      r_cpu_rdat <= '0;
      r_ren_rdat <= '0;
    end else begin
      r_tag_p0 <= tag_e'(i_tag);
      r_tag_p1 <= r_tag_p0;
      if (r_tag_p0 == TAG_CPU_RD) r_cpu_rdat <= i_mem_rdat;
      if (r_tag_p0 == TAG_REN)    r_ren_rdat <= i_mem_rdat;
    end
  end

  assign o_cpu_ack   = (r_tag_p1 == TAG_CPU_RD) || (r_tag_p1 == TAG_CPU_WR);
  assign o_ren_valid = (r_tag_p1 == TAG_REN);
  assign o_cpu_rdat  = r_cpu_rdat;
  assign o_ren_rdat  = r_ren_rdat;

endmodule

// File: rtl/vram_access_arbiter.sv
// Shares the single VDP VRAM port between the CPU data-port engine and the renderer
// fetcher. Renderer has priority; a starvation counter guarantees the CPU a slot.
module vram_access_arbiter
  import vram_access_arbiter_pkg::*;
#(
  parameter int AW         = VRAM_AW,
  parameter int DW         = 8,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_adr,
  input  logic [DW-1:0] cpu_wdat,
  output logic          cpu_gnt,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_rdat,
  input  logic          ren_req,
  input  logic [AW-1:0] ren_adr,
  output logic          ren_gnt,
  output logic          ren_valid,
  output logic [DW-1:0] ren_rdat,
  output logic [AW-1:0] mem_adr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdat,
  input  logic [DW-1:0] mem_rdat
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve_max
    $error("vram_access_arbiter: STARVE_MAX must be in 1..15");
  end

  logic          r_cpu_busy;
  logic [3:0]    r_starve_cnt;
  logic [AW-1:0] r_mem_adr;
  logic          r_mem_we;
  logic [DW-1:0] r_mem_wdat;

  logic          w_cpu_ok;
  logic          w_cpu_wins;
  logic          w_cpu_gnt;
  logic          w_ren_gnt;
  logic          w_cpu_ack;
  logic [1:0]    w_tag;

  // Grants are gated by rst_n so nothing is accepted while the pipeline is held in reset
  assign w_cpu_ok   = cpu_req & ~r_cpu_busy;
  assign w_cpu_wins = ~ren_req | (r_starve_cnt == STARVE_LIM);
  assign w_cpu_gnt  = rst_n & w_cpu_ok & w_cpu_wins;
  assign w_ren_gnt  = rst_n & ren_req & ~w_cpu_gnt;
  assign w_tag      = grant_tag(w_cpu_gnt, cpu_we, w_ren_gnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cpu_busy   <= 1'b0;
      r_starve_cnt <= '0;
    end else begin
      if (w_cpu_gnt)      r_cpu_busy <= 1'b1;
      else if (w_cpu_ack) r_cpu_busy <= 1'b0;

      if (!cpu_req || w_cpu_gnt)
        r_starve_cnt <= '0;
      else if (w_ren_gnt && w_cpu_ok && (r_starve_cnt != STARVE_LIM))
        r_starve_cnt <= r_starve_cnt + 4'd1;
    end
  end

  // Issue stage: the granted access drives the VRAM port for exactly one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_adr  <= '0;
      r_mem_we   <= 1'b0;
      r_mem_wdat <= '0;
    end else begin
      r_mem_we <= w_cpu_gnt & cpu_we;
      if (w_cpu_gnt) begin
        r_mem_adr  <= cpu_adr;
        r_mem_wdat <= cpu_wdat;
      end else if (w_ren_gnt) begin
        r_mem_adr  <= ren_adr;
      end
    end
  end

  vram_arb_retpipe #(
    .DW (DW)
  ) u_retpipe (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_tag       (w_tag),
    .i_mem_rdat  (mem_rdat),
    .o_cpu_ack   (w_cpu_ack),
    .o_cpu_rdat  (cpu_rdat),
    .o_ren_valid (ren_valid),
    .o_ren_rdat  (ren_rdat)
  );

  assign cpu_gnt  = w_cpu_gnt;
  assign ren_gnt  = w_ren_gnt;
  assign cpu_ack  = w_cpu_ack;
  assign mem_adr  = r_mem_adr;
  assign mem_we   = r_mem_we;
  assign mem_wdat = r_mem_wdat;

endmodule
